// File: rtl/tm_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tm_sample_sequencer
// Purpose  : Front end for the Tsetlin Machine inference core. Loads the
//            clause exclude masks from a valid/ready word stream, then feeds
//            feature vectors one at a time to the core. After the core's
//            latency it captures the class output and offers it on a
//            valid/ready result port. One sample is outstanding at most.
// Ports    : clk, rst        - clock, async active-high reset
//            s_valid/s_ready - input word handshake
//            s_cfg, s_data   - word kind (1 = mask, 0 = feature) and payload
//            features        - feature vector to the core
//            ex_masks        - flattened clause masks, clause i at [i*W +: W]
//            cfg_valid       - full mask set loaded
//            class_in        - class output of the core
//            res_valid/res_ready/res_class - result handshake and class
//            res_count       - delivered result count (wraps)
//            cfg_err         - sticky: feature word seen while unconfigured
// Revision : 1.0 - initial release
// ============================================================================
module tm_sample_sequencer #(
  parameter int NUM_FEATURES = 2,
  parameter int NUM_CLAUSES  = 8,
  parameter int INF_LAT      = 0,
  parameter int CLASS_W      = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic                                  s_cfg,
  input  logic [2*NUM_FEATURES-1:0]             s_data,
  output logic [NUM_FEATURES-1:0]               features,
  output logic [NUM_CLAUSES*2*NUM_FEATURES-1:0] ex_masks,
  output logic                                  cfg_valid,
  input  logic [CLASS_W-1:0]                    class_in,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [CLASS_W-1:0]                    res_class,
  output logic [15:0]                           res_count,
  output logic                                  cfg_err
);

  localparam int c_W     = 2 * NUM_FEATURES;
  localparam int c_IDX_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int c_CNT_W = (INF_LAT > 0) ? $clog2(INF_LAT + 1) : 1;

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_CLAUSES - 1);
  localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(INF_LAT);

  localparam logic [1:0] c_ST_CFG  = 2'd0;
  localparam logic [1:0] c_ST_IDLE = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;
  localparam logic [1:0] c_ST_RESP = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic                     w_ready;
  logic                     w_accept;
  logic [c_IDX_W-1:0]       r_idx;
  logic [c_CNT_W-1:0]       r_cnt;
  logic [c_W-1:0]           r_mask [NUM_CLAUSES];
  logic [NUM_FEATURES-1:0]  r_features;
  logic                     r_cfg_valid;
  logic                     r_res_valid;
  logic [CLASS_W-1:0]       r_res_class;
  logic [15:0]              r_res_count;
  logic                     r_cfg_err;

  assign w_accept = s_valid && w_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_CFG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_CFG: begin
        if (w_accept && s_cfg && (r_idx == c_LAST_IDX)) w_state_nxt = c_ST_IDLE;
      end
      c_ST_IDLE: begin
        if (w_accept) begin
          if (!s_cfg)               w_state_nxt = c_ST_WAIT;
          // A single-clause set is complete with its first word.
          else if (NUM_CLAUSES > 1) w_state_nxt = c_ST_CFG;
        end
      end
      c_ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = c_ST_RESP;
      end
      default: begin  // c_ST_RESP
        if (res_ready) w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    w_ready = (r_state == c_ST_CFG) || (r_state == c_ST_IDLE);
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_features  <= '0;
      r_cfg_valid <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_class <= '0;
      r_res_count <= '0;
      r_cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_CLAUSES; i++) r_mask[i] <= '0;
    end else begin
      case (r_state)
        c_ST_CFG: begin
          if (w_accept) begin
            if (s_cfg) begin
              r_mask[r_idx] <= s_data;
              if (r_idx == c_LAST_IDX) begin
                r_idx       <= '0;
                r_cfg_valid <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        c_ST_IDLE: begin
          if (w_accept) begin
            if (!s_cfg) begin
              r_features <= s_data[NUM_FEATURES-1:0];
              r_cnt      <= c_LAT_LOAD;
            end else begin
              r_mask[0] <= s_data;
              if (NUM_CLAUSES > 1) begin
                r_idx       <= c_IDX_W'(1);
                r_cfg_valid <= 1'b0;
              end
            end
          end
        end
        c_ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_res_class <= class_in;
            r_res_valid <= 1'b1;
          end
        end
        default: begin  // c_ST_RESP: result held until consumed
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_res_count <= r_res_count + 16'd1;
          end
        end
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_CLAUSES; g++) begin : g_flat
      assign ex_masks[g*c_W +: c_W] = r_mask[g];
    end
  endgenerate

  assign s_ready   = w_ready;
  assign features  = r_features;
  assign cfg_valid = r_cfg_valid;
  assign res_valid = r_res_valid;
  assign res_class = r_res_class;
  assign res_count = r_res_count;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_tm_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm_sample_sequencer
// Purpose  : Directed self-checking bench for tm_sample_sequencer with
//            NUM_FEATURES=2, NUM_CLAUSES=8, INF_LAT=1, CLASS_W=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_cfg = 1'b0;
  logic [3:0]  s_data = '0;
  logic [1:0]  features;
  logic [31:0] ex_masks;
  logic        cfg_valid;
  logic [1:0]  class_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [1:0]  res_class;
  logic [15:0] res_count;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  tm_sample_sequencer #(
    .NUM_FEATURES(2),
    .NUM_CLAUSES (8),
    .INF_LAT     (1),
    .CLASS_W     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_cfg    (s_cfg),
    .s_data   (s_data),
    .features (features),
    .ex_masks (ex_masks),
    .cfg_valid(cfg_valid),
    .class_in (class_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_class(res_class),
    .res_count(res_count),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for a single cycle (s_ready is expected to be high).
  task automatic send_word(input logic cfg, input logic [3:0] data);
    s_valid = 1'b1;
    s_cfg   = cfg;
    s_data  = data;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_masks"},  ex_masks,  '0);
    check_val({tag, "_feat"},   features,  '0);
    check_val({tag, "_cfgv"},   cfg_valid, '0);
    check_val({tag, "_resv"},   res_valid, '0);
    check_val({tag, "_resc"},   res_class, '0);
    check_val({tag, "_cnt"},    res_count, '0);
    check_val({tag, "_err"},    cfg_err,   '0);
    check_val({tag, "_ready"},  s_ready,   1'b1);
  endtask

  logic [3:0] masks1 [8] = '{4'b1100, 4'b1001, 4'b1100, 4'b0110,
                             4'b0101, 4'b1100, 4'b0001, 4'b0011};

  initial begin
    // ---------------- Reset state
    #2 rst = 1'b1;
    #1;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // ---------------- 1: back-to-back mask load
    for (int i = 0; i < 8; i++) begin
      check_val("t1_ready", s_ready, 1'b1);
      check_val("t1_cfgv_low", cfg_valid, 1'b0);
      s_valid = 1'b1; s_cfg = 1'b1; s_data = masks1[i];
      tick();
    end
    s_valid = 1'b0;
    check_val("t1_cfgv", cfg_valid, 1'b1);
    check_val("t1_masks", ex_masks, 32'h31C56C9C);
    check_val("t1_ready_idle", s_ready, 1'b1);

    // ---------------- 2: one sample, INF_LAT=1
    class_in = 2'b10;
    send_word(1'b0, 4'b0011);
    check_val("t2_feat", features, 2'b11);
    check_val("t2_ready_w0", s_ready, 1'b0);
    check_val("t2_resv_w0", res_valid, 1'b0);
    tick();
    check_val("t2_ready_w1", s_ready, 1'b0);
    check_val("t2_resv_w1", res_valid, 1'b0);
    tick();
    check_val("t2_resv", res_valid, 1'b1);
    check_val("t2_class", res_class, 2'b10);
    check_val("t2_cnt0", res_count, 16'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_val("t2_resv_done", res_valid, 1'b0);
    check_val("t2_cnt1", res_count, 16'd1);
    check_val("t2_ready_idle", s_ready, 1'b1);

    // ---------------- 3: result backpressure
    class_in = 2'b01;
    send_word(1'b0, 4'b0001);
    tick();
    tick();
    check_val("t3_resv", res_valid, 1'b1);
    check_val("t3_class", res_class, 2'b01);
    s_valid = 1'b1; s_cfg = 1'b0; s_data = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      class_in = class_in + 2'd1;
      tick();
      check_val("t3_hold_class", res_class, 2'b01);
      check_val("t3_hold_valid", res_valid, 1'b1);
      check_val("t3_hold_ready", s_ready, 1'b0);
      check_val("t3_hold_feat", features, 2'b01);
      check_val("t3_hold_cnt", res_count, 16'd1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_val("t3_release_cnt", res_count, 16'd2);
    check_val("t3_release_ready", s_ready, 1'b1);
    check_val("t3_feat_old", features, 2'b01);
    tick();
    s_valid = 1'b0;
    check_val("t3_next_feat", features, 2'b10);
    class_in = 2'b11;
    tick();
    tick();
    check_val("t3_next_class", res_class, 2'b11);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_val("t3_next_cnt", res_count, 16'd3);

    // ---------------- 5: reconfiguration from IDLE
    send_word(1'b1, 4'b1111);
    check_val("t5_cfgv_low", cfg_valid, 1'b0);
    check_val("t5_masks", ex_masks, 32'h31C56C9F);
    check_val("t5_err0", cfg_err, 1'b0);
    send_word(1'b0, 4'b0001);
    check_val("t5_err", cfg_err, 1'b1);
    check_val("t5_feat_kept", features, 2'b10);
    check_val("t5_ready", s_ready, 1'b1);
    for (int i = 0; i < 7; i++) begin
      check_val("t5_cfgv_pending", cfg_valid, 1'b0);
      send_word(1'b1, 4'b0000);
    end
    check_val("t5_cfgv", cfg_valid, 1'b1);
    check_val("t5_masks_new", ex_masks, 32'h0000000F);
    check_val("t5_err_sticky", cfg_err, 1'b1);

    // ---------------- 6: async reset mid-WAIT and mid-RESP
    send_word(1'b0, 4'b0011);
    #2 rst = 1'b1;
    #1;
    check_all_zero("t6_wait");
    #2 rst = 1'b0;
    tick();
    check_val("t6_ready_after", s_ready, 1'b1);
    for (int i = 0; i < 8; i++) send_word(1'b1, masks1[i]);
    check_val("t6_cfgv", cfg_valid, 1'b1);
    class_in = 2'b10;
    send_word(1'b0, 4'b0011);
    tick();
    tick();
    check_val("t6_resp_valid", res_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("t6_resp");
    #2 rst = 1'b0;
    tick();

    // ---------------- 4: feature before configuration
    send_word(1'b0, 4'b0001);
    check_val("t4_err", cfg_err, 1'b1);
    check_val("t4_feat", features, 2'b00);
    check_val("t4_ready", s_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_val("t4_cfgv_pending", cfg_valid, 1'b0);
      send_word(1'b1, masks1[i]);
    end
    check_val("t4_cfgv", cfg_valid, 1'b1);
    check_val("t4_masks", ex_masks, 32'h31C56C9C);
    check_val("t4_err_sticky", cfg_err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
